// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and defaults for the SPI arbiter.
//   arb_state_t     : sequencer state (IDLE, LAUNCH, BUSY, DONE)
//   req_id_t        : requester index, 0 or 1
//   TIMEOUT_CYC_DEF : default watchdog window in clk cycles
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef logic req_id_t;

    localparam int unsigned TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/xact_timer.sv
// xact_timer: watchdog for one SPI transaction.
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : reload the window (asserted in the launch cycle)
//   i_run      : count down (asserted while waiting for completion)
//   o_expired  : high in the cycle that is TIMEOUT_CYC-1 cycles after the launch
module xact_timer #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);
    // The first waiting cycle follows the reload, so the terminal count is
    // reached TIMEOUT_CYC-1 cycles after launch with a reload of TIMEOUT_CYC-2.
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 2);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= LOAD;
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = i_run && (r_cnt == '0);

endmodule

// File: rtl/spi_arb.sv
// spi_arb: two-requester round-robin arbiter and sequencer for one SPI monarch.
//   clk, rst           : clock, synchronous active-high reset
//   req0/1, lock0/1    : level request, keep-ownership request
//   cmd0/1             : command word, taken when the request is accepted
//   gnt0/1             : requester owns the SPI
//   done0/1, err0/1    : one-cycle completion / timeout pulses
//   resp0/1            : last response per requester
//   spi_snd, spi_cmd   : start pulse and command towards the SPI monarch
//   spi_done, spi_resp : completion pulse and response from the SPI monarch
//
// state  | meaning
// IDLE   | arbitrate, or wait on the lock holder
// LAUNCH | spi_snd pulse, watchdog reload
// BUSY   | waiting for spi_done or watchdog expiry
// DONE   | done pulse, round-robin and lock update
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] resp0,
    output logic [15:0] resp1,
    output logic        err0,
    output logic        err1,
    output logic        spi_snd,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_resp
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    req_id_t     r_owner;
    req_id_t     r_last;
    logic        r_lock_held;
    logic [15:0] r_cmd_q;
    logic [15:0] r_resp0;
    logic [15:0] r_resp1;
    logic        r_err0;
    logic        r_err1;

    logic [1:0]  w_req;
    logic [1:0]  w_lock;
    logic        w_accept;
    logic        w_release;
    req_id_t     w_win;
    logic        w_expired;
    logic        w_timeout;
    logic        w_active;

    assign w_req  = {req1, req0};
    assign w_lock = {lock1, lock0};

    xact_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == LAUNCH),
        .i_run     (r_state == BUSY),
        .o_expired (w_expired)
    );

    // A completion in the expiry cycle still counts as success.
    assign w_timeout = (r_state == BUSY) && w_expired && !spi_done;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        w_win       = r_owner;
        case (r_state)
            IDLE: begin
                if (r_lock_held) begin
                    if (w_req[r_owner]) begin
                        w_accept = 1'b1;
                    end else if (!w_lock[r_owner]) begin
                        w_release = 1'b1;
                    end
                end else if (req0 && req1) begin
                    w_accept = 1'b1;
                    w_win    = ~r_last;
                end else if (req0 || req1) begin
                    w_accept = 1'b1;
                    w_win    = req1;
                end
                if (w_accept) begin
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: w_state_nxt = BUSY;
            BUSY: begin
                if (spi_done) begin
                    w_state_nxt = DONE;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_lock_held <= 1'b0;
            r_cmd_q     <= '0;
            r_resp0     <= '0;
            r_resp1     <= '0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            if (w_accept) begin
                r_owner <= w_win;
                r_cmd_q <= w_win ? cmd1 : cmd0;
            end
            if (w_release) begin
                r_lock_held <= 1'b0;
            end
            if ((r_state == BUSY) && spi_done) begin
                if (r_owner) r_resp1 <= spi_resp;
                else         r_resp0 <= spi_resp;
            end
            if (w_timeout) begin
                r_err0      <= !r_owner;
                r_err1      <= r_owner;
                r_lock_held <= 1'b0;
                r_last      <= r_owner;
            end
            if (r_state == DONE) begin
                r_last      <= r_owner;
                r_lock_held <= w_lock[r_owner];
            end
        end
    end

    // Ownership spans the whole transaction plus any idle time under lock.
    assign w_active = (r_state != IDLE) || r_lock_held;

    assign gnt0    = w_active && !r_owner;
    assign gnt1    = w_active && r_owner;
    assign done0   = (r_state == DONE) && !r_owner;
    assign done1   = (r_state == DONE) && r_owner;
    assign err0    = r_err0;
    assign err1    = r_err1;
    assign resp0   = r_resp0;
    assign resp1   = r_resp1;
    assign spi_snd = (r_state == LAUNCH);
    assign spi_cmd = r_cmd_q;

endmodule

// File: tb/tb_spi_arb.sv
module tb_spi_arb;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
    logic [15:0] cmd0 = '0, cmd1 = '0;
    logic        gnt0, gnt1, done0, done1, err0, err1, spi_snd;
    logic [15:0] resp0, resp1, spi_cmd;
    logic        spi_done = 0;
    logic [15:0] spi_resp = '0;

    int checks = 0;
    int failures = 0;

    spi_arb #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .cmd0(cmd0), .cmd1(cmd1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .resp0(resp0), .resp1(resp1), .err0(err0), .err1(err1),
        .spi_snd(spi_snd), .spi_cmd(spi_cmd),
        .spi_done(spi_done), .spi_resp(spi_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Reference model, transaction view: who holds the bus, how many cycles
    // since its spi_snd, whether it is in its completion cycle, and who
    // (if anyone) keeps the bus between transactions.
    int          m_owner = -1;
    int          m_age = 0;
    bit          m_fin = 0;
    int          m_last = 1;
    int          m_locked = -1;
    int          m_err = -1;
    int          m_w;
    logic [15:0] m_cmd = '0;
    logic [15:0] m_resp [2];
    logic        s_req [2];
    logic        s_lock [2];
    logic [15:0] s_cmd [2];

    always @(posedge clk) begin
        #1;
        s_req[0] = req0;   s_req[1] = req1;
        s_lock[0] = lock0; s_lock[1] = lock1;
        s_cmd[0] = cmd0;   s_cmd[1] = cmd1;
        if (rst) begin
            m_owner = -1; m_age = 0; m_fin = 0; m_last = 1; m_locked = -1;
            m_err = -1; m_cmd = '0; m_resp[0] = '0; m_resp[1] = '0;
        end else begin
            m_err = -1;
            if (m_owner >= 0 && m_fin) begin
                m_last = m_owner;
                m_locked = s_lock[m_owner] ? m_owner : -1;
                m_owner = -1;
                m_fin = 0;
            end else if (m_owner >= 0) begin
                if (m_age >= 1 && spi_done) begin
                    m_resp[m_owner] = spi_resp;
                    m_fin = 1;
                end else if (m_age == TO - 1) begin
                    m_err = m_owner;
                    m_last = m_owner;
                    m_locked = -1;
                    m_owner = -1;
                end else begin
                    m_age++;
                end
            end else begin
                m_w = -1;
                if (m_locked >= 0) begin
                    if (s_req[m_locked]) m_w = m_locked;
                    else if (!s_lock[m_locked]) m_locked = -1;
                end else if (s_req[0] && s_req[1]) m_w = 1 - m_last;
                else if (s_req[0]) m_w = 0;
                else if (s_req[1]) m_w = 1;
                if (m_w >= 0) begin
                    m_owner = m_w; m_cmd = s_cmd[m_w]; m_age = 0;
                end
            end
        end
        chk("m_gnt0", 16'(gnt0), 16'(m_owner == 0 || (m_owner < 0 && m_locked == 0)));
        chk("m_gnt1", 16'(gnt1), 16'(m_owner == 1 || (m_owner < 0 && m_locked == 1)));
        chk("m_snd", 16'(spi_snd), 16'(m_owner >= 0 && !m_fin && m_age == 0));
        chk("m_cmd", spi_cmd, m_cmd);
        chk("m_done0", 16'(done0), 16'(m_fin && m_owner == 0));
        chk("m_done1", 16'(done1), 16'(m_fin && m_owner == 1));
        chk("m_err0", 16'(err0), 16'(m_err == 0));
        chk("m_err1", 16'(err1), 16'(m_err == 1));
        chk("m_resp0", resp0, m_resp[0]);
        chk("m_resp1", resp1, m_resp[1]);
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        cmd0 = '0; cmd1 = '0; spi_done = 0; spi_resp = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step(2);
        rst = 0;
    endtask

    task automatic wait_snd();
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (spi_snd) break;
        end
        chk("snd_seen", 16'(spi_snd), 16'd1);
    endtask

    task automatic finish_xact(input logic [15:0] r, input int dly);
        step(dly);
        spi_done = 1; spi_resp = r;
        step(1);
        spi_done = 0;
    endtask

    int cnt;
    bit seen;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        step(2);
        chk("rst_gnt0", 16'(gnt0), 16'd0);
        chk("rst_gnt1", 16'(gnt1), 16'd0);
        chk("rst_snd", 16'(spi_snd), 16'd0);
        chk("rst_cmd", spi_cmd, 16'h0000);
        chk("rst_done0", 16'(done0), 16'd0);
        chk("rst_err0", 16'(err0), 16'd0);
        chk("rst_resp0", resp0, 16'h0000);
        chk("rst_resp1", resp1, 16'h0000);
        rst = 0;

        // single request
        req0 = 1; cmd0 = 16'hA600;
        step(1);
        chk("single_snd", 16'(spi_snd), 16'd1);
        chk("single_cmd", spi_cmd, 16'hA600);
        chk("single_gnt0", 16'(gnt0), 16'd1);
        req0 = 0;
        seen = 0;
        for (int i = 0; i < 39; i++) begin
            step(1);
            if (gnt1) seen = 1;
        end
        spi_done = 1; spi_resp = 16'h0012;
        step(1);
        spi_done = 0;
        chk("single_done0", 16'(done0), 16'd1);
        chk("single_resp0", resp0, 16'h0012);
        step(1);
        chk("single_done0_off", 16'(done0), 16'd0);
        chk("single_gnt1_never", 16'(seen), 16'd0);

        // simultaneous request, round robin 0,1,0,1
        do_reset();
        req0 = 1; cmd0 = 16'h1111; req1 = 1; cmd1 = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            wait_snd();
            chk("rr_owner", 16'(gnt1), 16'(k % 2));
            chk("rr_cmd", spi_cmd, (k % 2) ? 16'h2222 : 16'h1111);
            finish_xact(16'(k), 3);
        end
        req0 = 0; req1 = 0;
        step(3);

        // lock
        do_reset();
        req0 = 1; lock0 = 1; cmd0 = 16'hA600; req1 = 1; cmd1 = 16'hB100;
        wait_snd();
        chk("lock_first_gnt0", 16'(gnt0), 16'd1);
        chk("lock_first_cmd", spi_cmd, 16'hA600);
        finish_xact(16'h0001, 3);
        cmd0 = 16'hA700;
        wait_snd();
        chk("lock_second_gnt0", 16'(gnt0), 16'd1);
        chk("lock_second_cmd", spi_cmd, 16'hA700);
        finish_xact(16'h0002, 3);
        req0 = 0;
        step(1);
        chk("lock_hold_gnt0", 16'(gnt0), 16'd1);
        chk("lock_hold_snd", 16'(spi_snd), 16'd0);
        lock0 = 0;
        step(1);
        chk("lock_rel_gnt0", 16'(gnt0), 16'd0);
        chk("lock_rel_gnt1", 16'(gnt1), 16'd0);
        step(1);
        chk("lock_next_gnt1", 16'(gnt1), 16'd1);
        chk("lock_next_snd", 16'(spi_snd), 16'd1);
        chk("lock_next_cmd", spi_cmd, 16'hB100);
        req1 = 0;
        finish_xact(16'h0003, 2);
        step(2);

        // timeout
        do_reset();
        req0 = 1; lock0 = 1; cmd0 = 16'hC000; req1 = 1; cmd1 = 16'hC111;
        wait_snd();
        chk("to_gnt0", 16'(gnt0), 16'd1);
        cnt = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            cnt++;
            if (done0) seen = 1;
            if (err0) break;
        end
        chk("to_err0", 16'(err0), 16'd1);
        chk("to_latency", 16'(cnt), 16'(TO));
        chk("to_no_done0", 16'(seen), 16'd0);
        chk("to_lock_cleared", 16'(gnt0), 16'd0);
        wait_snd();
        chk("to_next_gnt1", 16'(gnt1), 16'd1);
        chk("to_next_cmd", spi_cmd, 16'hC111);
        req0 = 0; req1 = 0; lock0 = 0;
        finish_xact(16'h0004, 2);
        step(2);

        // reset mid-BUSY
        do_reset();
        req0 = 1; cmd0 = 16'hD00D;
        wait_snd();
        req0 = 0;
        step(5);
        rst = 1;
        step(1);
        chk("mrst_gnt0", 16'(gnt0), 16'd0);
        chk("mrst_snd", 16'(spi_snd), 16'd0);
        chk("mrst_cmd", spi_cmd, 16'h0000);
        chk("mrst_done0", 16'(done0), 16'd0);
        chk("mrst_err0", 16'(err0), 16'd0);
        rst = 0;
        spi_done = 1; spi_resp = 16'hFFFF;
        step(1);
        spi_done = 0;
        chk("stale_done0", 16'(done0), 16'd0);
        chk("stale_resp0", resp0, 16'h0000);
        req0 = 1; cmd0 = 16'hD00E;
        wait_snd();
        chk("clean_cmd", spi_cmd, 16'hD00E);
        req0 = 0;
        finish_xact(16'h1234, 3);
        chk("clean_done0", 16'(done0), 16'd1);
        chk("clean_resp0", resp0, 16'h1234);
        step(2);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) req0 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) req1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) lock0 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) lock1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) cmd0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) cmd1 = 16'($urandom);
            spi_done = ($urandom_range(0, 24) == 0);
            spi_resp = 16'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 0;
        clear_inputs();
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
